memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter.sv | 136 +++++++++++++
 tb/tb_memory_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates CPU fetch and data ports onto one single-port memory with a req/ack
// handshake and a wait-cycle watchdog. Optional: MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ready,
  output logic [DATA_WIDTH-1:0] o_if_instruction,
  input  logic                  i_dm_req,
  input  logic                  i_dm_rw,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_ready,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_rw,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall,
  output logic                  o_timeout,
  output logic [1:0]            o_grant
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       if_elig, dm_elig, pick_dm, abort, finish;

  // A requester whose ready pulse is still showing has already been served.
  assign if_elig = i_if_req & ~o_if_ready;
  assign dm_elig = i_dm_req & ~o_dm_ready;
  assign o_stall = if_elig | dm_elig;

  assign o_mem_req = (state != IDLE);
  assign o_grant   = {state == GRANT_DM, state == GRANT_IF};
  assign abort     = (state != IDLE) & ~i_mem_ack & (wait_cnt == WAIT_LIMIT);
  assign finish    = (state != IDLE) & (i_mem_ack | abort);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last_dm;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_dm <= pick_dm;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick_dm   = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && dm_elig) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          pick_dm = ~last_dm;
`else
          pick_dm = 1'b1;
`endif
        end else begin
          pick_dm = dm_elig;
        end
        if (if_elig || dm_elig) state_nxt = pick_dm ? GRANT_DM : GRANT_IF;
      end
      GRANT_IF, GRANT_DM: begin
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt         <= '0;
      o_mem_rw         <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= '0;
      o_if_ready       <= 1'b0;
      o_dm_ready       <= 1'b0;
      o_if_instruction <= '0;
      o_dm_rdata       <= '0;
      o_timeout        <= 1'b0;
    end else begin
      o_if_ready <= 1'b0;
      o_dm_ready <= 1'b0;
      o_timeout  <= 1'b0;
      if (state == IDLE) begin
        if (state_nxt != IDLE) begin
          wait_cnt <= '0;
          if (pick_dm) begin
            o_mem_rw    <= i_dm_rw;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
          end else begin
            o_mem_rw    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
          end
        end
      end else if (finish) begin
        o_timeout <= abort;
        if (state == GRANT_IF) begin
          o_if_ready       <= 1'b1;
          o_if_instruction <= abort ? '0 : i_mem_rdata;
        end else begin
          o_dm_ready <= 1'b1;
          o_dm_rdata <= (abort || o_mem_rw) ? '0 : i_mem_rdata;
        end
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_rw, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          o_if_ready, o_dm_ready, o_mem_req, o_mem_rw, o_stall, o_timeout;
  logic [DW-1:0] o_if_instruction, o_dm_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    o_grant;

  int n_tests = 0;
  int n_fail  = 0;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ready(o_if_ready), .o_if_instruction(o_if_instruction),
    .i_dm_req(dm_req), .i_dm_rw(dm_rw), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_ready(o_dm_ready), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_stall(o_stall), .o_timeout(o_timeout), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  // Reference model: who owns memory, when it was granted, and what was latched.
  int            m_owner;       // 0 none, 1 fetch, 2 data
  int            m_last;
  int            cyc, m_grant_cyc;
  logic [AW-1:0] m_addr;
  logic          m_rw;
  logic [DW-1:0] m_wdata, m_if_data, m_dm_data;
  logic          m_if_rdy, m_dm_rdy, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 1; cyc = 0; m_grant_cyc = 0;
    m_addr = '0; m_rw = 1'b0; m_wdata = '0;
    m_if_data = '0; m_dm_data = '0;
    m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_edge();
    logic e_if, e_dm, n_if, n_dm, n_to;
    int   pick;
    e_if = if_req && !m_if_rdy;
    e_dm = dm_req && !m_dm_rdy;
    n_if = 1'b0; n_dm = 1'b0; n_to = 1'b0;
    cyc++;
    if (m_owner == 0) begin
      pick = 0;
      if (e_if && e_dm) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        pick = (m_last == 1) ? 2 : 1;
`else
        pick = 2;
`endif
      end else if (e_dm) pick = 2;
      else if (e_if) pick = 1;
      if (pick == 2) begin m_addr = dm_addr; m_rw = dm_rw; m_wdata = dm_wdata; end
      if (pick == 1) begin m_addr = if_addr; m_rw = 1'b0; end
      if (pick != 0) begin m_owner = pick; m_last = pick; m_grant_cyc = cyc; end
    end else if (mem_ack || (cyc - m_grant_cyc) == MW + 1) begin
      n_to = !mem_ack;
      if (m_owner == 1) begin n_if = 1'b1; m_if_data = n_to ? '0 : mem_rdata; end
      else begin n_dm = 1'b1; m_dm_data = (n_to || m_rw) ? '0 : mem_rdata; end
      m_owner = 0;
    end
    m_if_rdy = n_if; m_dm_rdy = n_dm; m_to = n_to;
  endtask

  task automatic compare_model();
    check("m_mem_req", o_mem_req, m_owner != 0);
    check("m_grant", o_grant, m_owner);
    check("m_if_ready", o_if_ready, m_if_rdy);
    check("m_dm_ready", o_dm_ready, m_dm_rdy);
    check("m_timeout", o_timeout, m_to);
    check("m_stall", o_stall, (if_req && !m_if_rdy) || (dm_req && !m_dm_rdy));
    if (m_owner != 0) begin
      check("m_mem_addr", o_mem_addr, m_addr);
      check("m_mem_rw", o_mem_rw, m_rw);
      if (m_rw) check("m_mem_wdata", o_mem_wdata, m_wdata);
    end
    if (m_if_rdy) check("m_if_data", o_if_instruction, m_if_data);
    if (m_dm_rdy) check("m_dm_data", o_dm_rdata, m_dm_data);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic drain();
    mem_ack = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (m_if_rdy) if_req = 1'b0;
      if (m_dm_rdy) dm_req = 1'b0;
      if (!if_req && !dm_req && m_owner == 0) break;
      cycle();
    end
    check("drain_idle", {if_req, dm_req, o_mem_req}, 3'b000);
    mem_ack = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic        if_req, dm_req, dm_rw, ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [1:0]  e_grant;
    logic        e_ifr, e_dmr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t vec[9];
  int   order[$];
  int   cnt, ack_pct;

  initial begin
    vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'b01, 1'b0, 1'b0, 32'h0,        1'b1};
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    vec[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1};
    vec[4] = vec[3];
    vec[5] = vec[3];
    vec[6] = vec[3];
    vec[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0,        1'b0};
    vec[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_rw = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mem_req", o_mem_req, 0);
    check("rst_grant", o_grant, 0);
    check("rst_readys", {o_if_ready, o_dm_ready, o_timeout}, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_data", o_if_instruction | o_dm_rdata | o_mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: single fetch, then a write acked after three wait cycles.
    if_addr = 16'h0004; dm_addr = 16'h0100; dm_wdata = 32'h12345678;
    for (int i = 0; i < 9; i++) begin
      if_req = vec[i].if_req; dm_req = vec[i].dm_req; dm_rw = vec[i].dm_rw;
      mem_ack = vec[i].ack; mem_rdata = vec[i].rdata;
      cycle();
      check($sformatf("v%0d_mem_req", i), o_mem_req, vec[i].e_req);
      check($sformatf("v%0d_grant", i), o_grant, vec[i].e_grant);
      check($sformatf("v%0d_if_ready", i), o_if_ready, vec[i].e_ifr);
      check($sformatf("v%0d_dm_ready", i), o_dm_ready, vec[i].e_dmr);
      check($sformatf("v%0d_stall", i), o_stall, vec[i].e_stall);
      if (vec[i].e_grant == 2'b01) begin
        check($sformatf("v%0d_addr", i), o_mem_addr, 16'h0004);
        check($sformatf("v%0d_rw", i), o_mem_rw, 1'b0);
      end
      if (vec[i].e_grant == 2'b10) begin
        check($sformatf("v%0d_addr", i), o_mem_addr, 16'h0100);
        check($sformatf("v%0d_rw", i), o_mem_rw, 1'b1);
        check($sformatf("v%0d_wdata", i), o_mem_wdata, 32'h12345678);
      end
      if (vec[i].e_ifr) check($sformatf("v%0d_if_data", i), o_if_instruction, vec[i].e_data);
      if (vec[i].e_dmr) check($sformatf("v%0d_dm_data", i), o_dm_rdata, vec[i].e_data);
    end

    // Both requesters held: the just-served side sits out its ready cycle, so they alternate.
    if_addr = 16'h0010; dm_addr = 16'h0200; dm_rw = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    order.delete();
    for (int i = 0; i < 20 && order.size() < 4; i++) begin
      cycle();
      if (o_grant != 2'b00) order.push_back(int'(o_grant));
    end
    check("held_grant_count", order.size(), 4);
    if (order.size() == 4) begin
      check("held_grant0", order[0], 2);
      check("held_grant1", order[1], 1);
      check("held_grant2", order[2], 2);
      check("held_grant3", order[3], 1);
    end
    drain();

    // Fresh tie right after a data-only transaction.
    dm_req = 1'b1; mem_ack = 1'b1;
    drain();
    if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b0;
    cycle();
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    check("tie_after_dm", o_grant, 2'b01);
`else
    check("tie_after_dm", o_grant, 2'b10);
`endif
    drain();

    // Fresh tie right after a fetch-only transaction: data wins in both modes.
    if_req = 1'b1; mem_ack = 1'b1;
    drain();
    if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b0;
    cycle();
    check("tie_after_if", o_grant, 2'b10);
    drain();

    // Watchdog: memory never acks a data read.
    dm_req = 1'b1; dm_rw = 1'b0; dm_addr = 16'h0300; mem_ack = 1'b0; mem_rdata = 32'hFFFFFFFF;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (o_dm_ready) break;
      if (o_mem_req) cnt++;
    end
    check("wd_req_cycles", cnt, MW + 1);
    check("wd_ready", o_dm_ready, 1'b1);
    check("wd_timeout", o_timeout, 1'b1);
    check("wd_rdata", o_dm_rdata, 32'h0);
    dm_req = 1'b0; mem_ack = 1'b1;
    cycle();
    check("late_ack_ready", {o_dm_ready, o_if_ready, o_timeout}, 3'b000);
    check("late_ack_req", o_mem_req, 1'b0);
    mem_ack = 1'b0;
    cycle();

    // Reset during the second cycle of a fetch grant.
    if_req = 1'b1; if_addr = 16'h0020;
    cycle();
    cycle();
    check("pre_rst_req", o_mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_req", o_mem_req, 1'b0);
    check("rst_async_grant", o_grant, 2'b00);
    if_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_no_ready", o_if_ready, 1'b0);
    end
    if_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    cycle();
    cycle();
    check("post_rst_ready", o_if_ready, 1'b1);
    check("post_rst_data", o_if_instruction, 32'h0BADF00D);
    if_req = 1'b0; mem_ack = 1'b0;
    cycle();

    // Randomized traffic with varying memory responsiveness.
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 15;
          2: ack_pct = 50;
          default: ack_pct = 100;
        endcase
      end
      if (m_if_rdy || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom);
      end
      if (m_dm_rdy || !dm_req) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_rw = 1'($urandom);
        dm_addr = AW'($urandom);
        dm_wdata = $urandom;
      end
      mem_ack = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = $urandom;
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
